// File: rtl/hera_wb_arb.sv
// hera_wb_arb: write-back arbiter and hazard scoreboard for the HERA register
// file. Three producers (load return, multiplier, ALU) share one write port.
// A multiply occupies the port for two cycles (low word to rd, high word to
// R13). The scoreboard tracks destinations of loads/multiplies in flight and
// raises a hazard for decode sources that are still pending.
module hera_wb_arb #(
  parameter int STARVE_MAX = 4,
  parameter int DW         = 16
) (
  input  logic          clk,
  input  logic          rst_s,
  input  logic          ld_valid,
  input  logic [3:0]    ld_rd,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  input  logic          mul_valid,
  input  logic [3:0]    mul_rd,
  input  logic [DW-1:0] mul_lo,
  input  logic [DW-1:0] mul_hi,
  output logic          mul_ready,
  input  logic          alu_valid,
  input  logic [3:0]    alu_rd,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          iss_ld,
  input  logic          iss_mul,
  input  logic [3:0]    iss_rd,
  input  logic [3:0]    rsa,
  input  logic [3:0]    rsb,
  output logic          hazard,
  output logic          wr_en,
  output logic [3:0]    wr_addr,
  output logic [DW-1:0] wr_data,
  output logic [15:0]   pend
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [3:0] R13        = 4'd13;

  typedef enum logic [0:0] {IDLE, MUL_HI} state_t;

  state_t        state;
  logic [3:0]    starve_cnt;
  logic [DW-1:0] mul_hi_p1;
  logic [15:0]   set_mask;
  logic [15:0]   clr_mask;

  function automatic logic [15:0] reg_bit(input logic [3:0] r);
    return 16'h0001 << r;
  endfunction

  // Grant selection: ALU when starved, otherwise ld > mul > alu; nothing while the high word goes out
  always_comb begin
    ld_ready  = 1'b0;
    mul_ready = 1'b0;
    alu_ready = 1'b0;
    if (state == IDLE) begin
      if (alu_valid && (starve_cnt >= STARVE_LIM)) alu_ready = 1'b1;
      else if (ld_valid)                           ld_ready  = 1'b1;
      else if (mul_valid)                          mul_ready = 1'b1;
      else if (alu_valid)                          alu_ready = 1'b1;
    end
  end

  // Scoreboard set/clear masks for this edge; iss_mul overrides iss_ld, R0 never tracked
  always_comb begin
    set_mask = 16'h0000;
    clr_mask = 16'h0000;
    if (iss_mul)     set_mask = reg_bit(iss_rd) | reg_bit(R13);
    else if (iss_ld) set_mask = reg_bit(iss_rd);
    if (state == MUL_HI) clr_mask = reg_bit(R13);
    else if (ld_ready)   clr_mask = reg_bit(ld_rd);
    else if (mul_ready)  clr_mask = reg_bit(mul_rd);
  end

  assign hazard = ((rsa != 4'd0) && pend[rsa]) || ((rsb != 4'd0) && pend[rsb]);

  // Write port, multiply sequencing, starvation counter and pending mask
  always_ff @(posedge clk) begin
    if (rst_s) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      mul_hi_p1  <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= 4'd0;
      wr_data    <= '0;
      pend       <= 16'h0000;
    end else begin
      state <= IDLE;
      wr_en <= 1'b0;
      if (state == MUL_HI) begin
        wr_en   <= 1'b1;
        wr_addr <= R13;
        wr_data <= mul_hi_p1;
      end else if (ld_ready) begin
        wr_en   <= (ld_rd != 4'd0);
        wr_addr <= ld_rd;
        wr_data <= ld_data;
      end else if (mul_ready) begin
        wr_en     <= (mul_rd != 4'd0);
        wr_addr   <= mul_rd;
        wr_data   <= mul_lo;
        mul_hi_p1 <= mul_hi;
        state     <= MUL_HI;
      end else if (alu_ready) begin
        wr_en   <= (alu_rd != 4'd0);
        wr_addr <= alu_rd;
        wr_data <= alu_data;
      end

      if (!alu_valid || alu_ready)      starve_cnt <= 4'd0;
      else if (starve_cnt < STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;

      pend <= ((pend & ~clr_mask) | set_mask) & 16'hFFFE;
    end
  end

endmodule

// File: tb/tb_hera_wb_arb.sv
// tb_hera_wb_arb: directed scenarios followed by random traffic, all checked
// against a cycle-level reference model of the write-back rules.
module tb_hera_wb_arb;

  localparam int SM = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_s;
  logic          ld_valid, mul_valid, alu_valid;
  logic [3:0]    ld_rd, mul_rd, alu_rd;
  logic [DW-1:0] ld_data, mul_lo, mul_hi, alu_data;
  logic          ld_ready, mul_ready, alu_ready;
  logic          iss_ld, iss_mul;
  logic [3:0]    iss_rd, rsa, rsb;
  logic          hazard;
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic [15:0]   pend;

  hera_wb_arb #(.STARVE_MAX(SM), .DW(DW)) dut (
    .clk(clk), .rst_s(rst_s),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .mul_valid(mul_valid), .mul_rd(mul_rd), .mul_lo(mul_lo), .mul_hi(mul_hi), .mul_ready(mul_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .iss_ld(iss_ld), .iss_mul(iss_mul), .iss_rd(iss_rd), .rsa(rsa), .rsb(rsb),
    .hazard(hazard), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pend(pend)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  // reference model state
  bit          m_hi_busy;
  logic [15:0] m_hi_data;
  int          m_cnt;
  bit          m_pend[16];
  bit          m_wr_en;
  logic [3:0]  m_addr;
  logic [15:0] m_data;
  logic [15:0] rf[16];          // register file as seen through the DUT write port

  // values sampled before the last edge
  logic s_ld_ready, s_mul_ready, s_alu_ready, s_hazard;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_pend_vec();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic drive(input bit lv, input logic [3:0] lr, input logic [15:0] ld,
                       input bit mv, input logic [3:0] mr, input logic [15:0] lo, input logic [15:0] hi,
                       input bit av, input logic [3:0] ar, input logic [15:0] ad);
    ld_valid = lv; ld_rd = lr; ld_data = ld;
    mul_valid = mv; mul_rd = mr; mul_lo = lo; mul_hi = hi;
    alu_valid = av; alu_rd = ar; alu_data = ad;
  endtask

  task automatic issue(input bit il, input bit im, input logic [3:0] rd);
    iss_ld = il; iss_mul = im; iss_rd = rd;
  endtask

  // One clock: check combinational outputs, advance model, check registered outputs.
  task automatic tick();
    int g;          // 0 none, 1 ld, 2 mul, 3 alu
    bit exp_hz;
    #3;
    g = 0;
    if (!m_hi_busy) begin
      if (alu_valid && m_cnt >= SM) g = 3;
      else if (ld_valid)  g = 1;
      else if (mul_valid) g = 2;
      else if (alu_valid) g = 3;
    end
    exp_hz = (rsa != 0 && m_pend[rsa]) || (rsb != 0 && m_pend[rsb]);
    check("ld_ready",  ld_ready,  g == 1);
    check("mul_ready", mul_ready, g == 2);
    check("alu_ready", alu_ready, g == 3);
    check("hazard",    hazard,    exp_hz);
    s_ld_ready = ld_ready; s_mul_ready = mul_ready; s_alu_ready = alu_ready; s_hazard = hazard;

    if (rst_s) begin
      m_hi_busy = 0; m_hi_data = 0; m_cnt = 0; m_wr_en = 0; m_addr = 0; m_data = 0;
      for (int i = 0; i < 16; i++) m_pend[i] = 0;
    end else begin
      if (m_hi_busy) begin
        m_wr_en = 1; m_addr = 13; m_data = m_hi_data; m_pend[13] = 0; m_hi_busy = 0;
      end else if (g == 1) begin
        m_wr_en = (ld_rd != 0); m_addr = ld_rd; m_data = ld_data; m_pend[ld_rd] = 0;
      end else if (g == 2) begin
        m_wr_en = (mul_rd != 0); m_addr = mul_rd; m_data = mul_lo; m_pend[mul_rd] = 0;
        m_hi_busy = 1; m_hi_data = mul_hi;
      end else if (g == 3) begin
        m_wr_en = (alu_rd != 0); m_addr = alu_rd; m_data = alu_data;
      end else begin
        m_wr_en = 0;
      end
      if (!alu_valid || g == 3) m_cnt = 0;
      else if (m_cnt < SM) m_cnt = m_cnt + 1;
      if (iss_mul) begin m_pend[iss_rd] = 1; m_pend[13] = 1; end
      else if (iss_ld) m_pend[iss_rd] = 1;
      m_pend[0] = 0;
    end

    @(posedge clk);
    #1;
    check("wr_en",   wr_en,   m_wr_en);
    check("wr_addr", wr_addr, m_addr);
    check("wr_data", wr_data, m_data);
    check("pend",    pend,    m_pend_vec());
    if (wr_en === 1'b1) rf[wr_addr] = wr_data;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(0, 0, 0);
  endtask

  initial begin
    rst_s = 1'b1;
    idle();
    rsa = 0; rsb = 0;
    for (int i = 0; i < 16; i++) rf[i] = 16'h0;
    m_hi_busy = 0; m_cnt = 0;
    @(posedge clk); #1;
    tick();
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_pend",  pend,  16'h0000);
    rst_s = 1'b0;

    // reset while the high word is waiting
    issue(0, 1, 5);
    tick();
    issue(0, 0, 0);
    drive(0, 0, 0, 1, 5, 16'h1111, 16'h2222, 0, 0, 0);
    tick();
    check("rmul_grant", s_mul_ready, 1'b1);
    check("rmul_lo_addr", wr_addr, 4'd5);
    check("rmul_lo_data", wr_data, 16'h1111);
    idle();
    rst_s = 1'b1;
    tick();
    rst_s = 1'b0;
    check("rmul_wr_en", wr_en, 1'b0);
    check("rmul_pend",  pend,  16'h0000);
    tick();
    check("rmul_no_hi", wr_en, 1'b0);

    // simultaneous requests
    drive(1, 3, 16'hAAAA, 1, 4, 16'h4444, 16'h5555, 1, 6, 16'h6666);
    tick();
    check("sim_c0_ld", s_ld_ready, 1'b1);
    check("sim_w1", {wr_addr, wr_data}, {4'd3, 16'hAAAA});
    drive(0, 0, 0, 1, 4, 16'h4444, 16'h5555, 1, 6, 16'h6666);
    tick();
    check("sim_c1_mul", s_mul_ready, 1'b1);
    check("sim_w2", {wr_addr, wr_data}, {4'd4, 16'h4444});
    drive(0, 0, 0, 0, 0, 0, 0, 1, 6, 16'h6666);
    tick();
    check("sim_c2_none", {s_ld_ready, s_mul_ready, s_alu_ready}, 3'b000);
    check("sim_w3", {wr_addr, wr_data}, {4'd13, 16'h5555});
    tick();
    check("sim_c3_alu", s_alu_ready, 1'b1);
    check("sim_w4", {wr_addr, wr_data}, {4'd6, 16'h6666});
    idle();
    tick();

    // starvation: ALU forced through after SM denials
    for (int i = 0; i < 8; i++) begin
      drive(1, 4'(i + 1), 16'(i), 0, 0, 0, 0, 1, 9, 16'hBEEF);
      tick();
      check("starve_alu", s_alu_ready, i == SM);
      check("starve_ld",  s_ld_ready,  i != SM);
    end
    idle();
    tick();

    // scoreboard around a multiply to R7 and R13
    rsa = 13;
    issue(0, 1, 7);
    tick();
    issue(0, 0, 0);
    tick();
    check("sb_hz_set", s_hazard, 1'b1);
    drive(0, 0, 0, 1, 7, 16'h0707, 16'h1313, 0, 0, 0);
    tick();
    idle();
    tick();                       // high word written, pend[13] cleared on this edge
    check("sb_hz_hi_cycle", s_hazard, 1'b1);
    tick();
    check("sb_hz_clear", s_hazard, 1'b0);
    // set and clear of the same bit on one edge
    issue(1, 0, 2);
    tick();
    drive(1, 2, 16'h2020, 0, 0, 0, 0, 0, 0, 0);
    issue(1, 0, 2);
    tick();
    check("sb_set_wins", pend[2], 1'b1);
    idle();
    drive(1, 2, 16'h2121, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("sb_cleared", pend[2], 1'b0);

    // R0 handling
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 16'hFFFF);
    issue(1, 0, 0);
    rsa = 0; rsb = 0;
    tick();
    check("r0_ready", s_alu_ready, 1'b1);
    check("r0_wr_en", wr_en, 1'b0);
    check("r0_pend",  pend[0], 1'b0);
    idle();
    tick();
    check("r0_hazard", s_hazard, 1'b0);

    // mul to R13: high word lands last
    issue(0, 1, 13);
    tick();
    drive(0, 0, 0, 1, 13, 16'h0001, 16'h0002, 0, 0, 0);
    issue(0, 0, 0);
    tick();
    check("m13_lo", {wr_en, wr_addr, wr_data}, {1'b1, 4'd13, 16'h0001});
    idle();
    tick();
    check("m13_hi", {wr_en, wr_addr, wr_data}, {1'b1, 4'd13, 16'h0002});
    check("m13_pend", pend[13], 1'b0);
    check("m13_final", rf[13], 16'h0002);

    // random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      int r;
      rst_s = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 2) == 0, 4'($urandom), 16'($urandom),
            $urandom_range(0, 3) == 0, 4'($urandom), 16'($urandom), 16'($urandom),
            $urandom_range(0, 1) == 0, 4'($urandom), 16'($urandom));
      r = $urandom_range(0, 9);
      issue(r < 3, (r == 3) || (r == 9 && $urandom_range(0, 1) == 1), 4'($urandom));
      if (r == 9) iss_ld = 1'b1;
      rsa = 4'($urandom);
      rsb = 4'($urandom);
      tick();
    end
    rst_s = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
